// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweep_pkg;

   // Sweep controller states; encodings are fixed so they read the same in waveforms.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reflected binary Gray code of index, truncated to width bits.
   function automatic logic [7:0] gray_enc(input logic [7:0] index, input int width);
      logic [7:0] mask;
      mask = 8'((9'd1 << width) - 9'd1);
      return (index ^ (index >> 1)) & mask;
   endfunction

   // Number of rows in a truth table over n inputs.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/sweep_step_counter.sv
// Dwell and index counters for the sweeper: holds each step for DWELL
// enabled cycles, strobes on the last of them, then advances the index.
module sweep_step_counter #(
   parameter int N     = 4,
   parameter int DWELL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   output logic [N-1:0] index,
   output logic         sample_stb,
   output logic         last
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [DW-1:0] dwell;

   assign sample_stb = enable && (dwell == DW'(DWELL - 1));
   assign last       = (index == {N{1'b1}});

   // Count dwell cycles; on the strobe restart dwell and step the index.
   // The index stops at the last row and only returns to 0 through clear.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n || clear) begin
         dwell <= '0;
         index <= '0;
      end else if (enable) begin
         if (sample_stb) begin
            dwell <= '0;
            if (!last) index <= index + 1'b1;
         end else begin
            dwell <= dwell + 1'b1;
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and checker for a 1-output combinational DUT.
// Drives every N-bit pattern, samples dut_y after DWELL cycles, builds the
// captured truth table and compares it against EXPECTED.
// Optional build macro SWEEP_GRAY_EN: visit patterns in Gray-code order
// (tables and first_err_idx stay indexed by pattern value).
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int                      N        = 4,
   parameter int                      DWELL    = 1,
   parameter logic [tt_width(N)-1:0]  EXPECTED = 16'h6996
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic [N-1:0]             pattern,
   input  logic                     dut_y,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [tt_width(N)-1:0]   captured,
   output logic [N:0]               err_count,
   output logic [N-1:0]             first_err_idx
);

   state_t       state;
   state_t       state_next;
   logic         accept;
   logic         running;
   logic [N-1:0] index;
   logic         sample_stb;
   logic         last;
   logic [N-1:0] next_addr;
   logic         miss;

   assign accept  = (state == IDLE) && start;
   assign running = (state == RUN);
   assign miss    = (dut_y != EXPECTED[pattern]);

   sweep_step_counter #(
      .N     (N),
      .DWELL (DWELL)
   ) u_step (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (accept),
      .enable     (running),
      .index      (index),
      .sample_stb (sample_stb),
      .last       (last)
   );

   // Address of the pattern following the current index; index+1 never
   // overflows because it is only used while last is low.
`ifdef SWEEP_GRAY_EN
   assign next_addr = N'(gray_enc(8'(index) + 8'd1, N));
`else
   assign next_addr = index + 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and status decode; DONE lasts exactly one cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case can leave a value unassigned and infer a latch.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (sample_stb && last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pattern drive, capture and compare. The current pattern register is
   // itself the table address being sampled, so no second mapping is needed.
   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         // Both orders begin at pattern 0 (Gray code of 0 is 0).
         pattern       <= '0;
         captured      <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         pass          <= 1'b0;
      end else if (running && sample_stb) begin
         captured[pattern] <= dut_y;
         if (miss) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_idx <= pattern;
         end
         if (last) pass <= (err_count == '0) && !miss;
         else      pattern <= next_addr;
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (N=4, EXPECTED=16'h6996) driving a
// behavioural XOR-family DUT. DWELL is 2 by default, 1 in the Gray build.
`timescale 1ns/1ps
module tb_truth_table_sweeper;

`ifdef SWEEP_GRAY_EN
   localparam int DWELL         = 1;
   localparam int DONE_CYC      = 17;
   localparam int RISE2_CYC     = 19;
   localparam int DONE2_CYC     = 35;
   localparam int PRE_RST_ERRS  = 9;
   localparam logic [3:0] LAST_PAT = 4'h8;
   localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`else
   localparam int DWELL         = 2;
   localparam int DONE_CYC      = 33;
   localparam int RISE2_CYC     = 35;
   localparam int DONE2_CYC     = 67;
   localparam int PRE_RST_ERRS  = 4;
   localparam logic [3:0] LAST_PAT = 4'hF;
   localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                       4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  pattern;
   logic        dut_y;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] captured;
   logic [4:0]  err_count;
   logic [3:0]  first_err_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int mode     = 0;   // 0: XOR, 1: XOR with row 5 inverted, 2: XNOR

   always #5 clk = ~clk;

   // Behavioural lab DUT.
   assign dut_y = (^pattern) ^ (mode == 2) ^ ((mode == 1) && (pattern == 4'd5));

   truth_table_sweeper #(
      .N        (4),
      .DWELL    (DWELL),
      .EXPECTED (16'h6996)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .pattern       (pattern),
      .dut_y         (dut_y),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .captured      (captured),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   // Start a sweep in cycle 0 and monitor cycles 1..max_cyc at each negedge.
   // repulse_at re-asserts start for one cycle; hold keeps start high and
   // also measures the second sweep.
   task automatic sweep(input int repulse_at, input bit hold, input int max_cyc,
                        output int done1, output int done2, output int rise2,
                        output int busy_cnt, output bit busy_at_done, output int pat_errs);
      done1 = -1; done2 = -1; rise2 = -1; busy_cnt = 0; busy_at_done = 1'b1; pat_errs = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (!hold) start = (c == repulse_at);
         if (done1 < 0) begin
            if (busy) begin
               busy_cnt++;
               if (c <= 16 * DWELL && pattern !== SEQ[(c - 1) / DWELL]) pat_errs++;
            end
            if (done) begin
               done1 = c;
               busy_at_done = busy;
               if (!hold) break;
            end
         end else begin
            if (busy && rise2 < 0) rise2 = c;
            if (done) begin
               done2 = c;
               break;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, pass, pattern, captured, err_count, first_err_idx} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b pass=%b pattern=%h captured=%h err=%0d idx=%0d, required all zero",
                  busy, done, pass, pattern, captured, err_count, first_err_idx);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_xor_pass;
      int d1, d2, r2, bc, pe;
      bit bad;
      mode = 0;
      sweep(-1, 1'b0, 100, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if (d1 !== DONE_CYC) begin n_fail++; $display("FAIL xor_done_cycle: got %0d, required %0d", d1, DONE_CYC); end
      n_checks++;
      if (bc !== 16 * DWELL) begin n_fail++; $display("FAIL xor_busy_cycles: got %0d, required %0d", bc, 16 * DWELL); end
      n_checks++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL xor_busy_at_done: got %b, required 0", bad); end
      n_checks++;
      if (pe !== 0) begin n_fail++; $display("FAIL xor_pattern_order: %0d wrong pattern cycles, required 0", pe); end
      n_checks++;
      if (pass !== 1'b1) begin n_fail++; $display("FAIL xor_pass: got %b, required 1", pass); end
      n_checks++;
      if (err_count !== 5'd0) begin n_fail++; $display("FAIL xor_err_count: got %0d, required 0", err_count); end
      n_checks++;
      if (captured !== 16'h6996) begin n_fail++; $display("FAIL xor_captured: got %h, required 6996", captured); end
      @(negedge clk);
      n_checks++;
      if ({done, pass, pattern} !== {1'b0, 1'b1, LAST_PAT}) begin
         n_fail++;
         $display("FAIL xor_after_done: done=%b pass=%b pattern=%h, required done=0 pass=1 pattern=%h",
                  done, pass, pattern, LAST_PAT);
      end
   endtask

   task automatic test_single_error;
      int d1, d2, r2, bc, pe;
      bit bad;
      mode = 1;
      sweep(-1, 1'b0, 100, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if (d1 !== DONE_CYC) begin n_fail++; $display("FAIL one_err_done_cycle: got %0d, required %0d", d1, DONE_CYC); end
      n_checks++;
      if (err_count !== 5'd1) begin n_fail++; $display("FAIL one_err_count: got %0d, required 1", err_count); end
      n_checks++;
      if (first_err_idx !== 4'd5) begin n_fail++; $display("FAIL one_err_first_idx: got %0d, required 5", first_err_idx); end
      n_checks++;
      if (pass !== 1'b0) begin n_fail++; $display("FAIL one_err_pass: got %b, required 0", pass); end
      n_checks++;
      if (captured !== 16'h69B6) begin n_fail++; $display("FAIL one_err_captured: got %h, required 69b6", captured); end
   endtask

   task automatic test_all_errors;
      int d1, d2, r2, bc, pe;
      bit bad;
      mode = 2;
      sweep(-1, 1'b0, 100, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if (err_count !== 5'd16) begin n_fail++; $display("FAIL xnor_err_count: got %0d, required 16", err_count); end
      n_checks++;
      if (first_err_idx !== 4'd0) begin n_fail++; $display("FAIL xnor_first_idx: got %0d, required 0", first_err_idx); end
      n_checks++;
      if (captured !== 16'h9669) begin n_fail++; $display("FAIL xnor_captured: got %h, required 9669", captured); end
      n_checks++;
      if (pass !== 1'b0) begin n_fail++; $display("FAIL xnor_pass: got %b, required 0", pass); end
   endtask

   task automatic test_reset_abort;
      int d1, d2, r2, bc, pe;
      bit bad;
      bit seen;
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);   // now in cycle 10
      n_checks++;
      if (err_count !== 5'(PRE_RST_ERRS)) begin
         n_fail++;
         $display("FAIL abort_pre_err_count: got %0d, required %0d", err_count, PRE_RST_ERRS);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, done, pass, pattern, err_count, captured} !== '0) begin
         n_fail++;
         $display("FAIL abort_cleared: busy=%b done=%b pass=%b pattern=%h err=%0d captured=%h, required all zero",
                  busy, done, pass, pattern, err_count, captured);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: activity seen=%b, required 0", seen); end
      mode = 0;
      sweep(-1, 1'b0, 100, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if ({d1 == DONE_CYC, pass, captured} !== {1'b1, 1'b1, 16'h6996}) begin
         n_fail++;
         $display("FAIL abort_resweep: done_cycle=%0d pass=%b captured=%h, required %0d 1 6996",
                  d1, pass, captured, DONE_CYC);
      end
   endtask

   task automatic test_back_to_back;
      int d1, d2, r2, bc, pe;
      bit bad;
      mode = 0;
      sweep(7, 1'b0, 100, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if (d1 !== DONE_CYC) begin n_fail++; $display("FAIL repulse_done_cycle: got %0d, required %0d", d1, DONE_CYC); end
      n_checks++;
      if (bc !== 16 * DWELL) begin n_fail++; $display("FAIL repulse_busy_cycles: got %0d, required %0d", bc, 16 * DWELL); end
      repeat (3) @(negedge clk);
      sweep(-1, 1'b1, 150, d1, d2, r2, bc, bad, pe);
      n_checks++;
      if (d1 !== DONE_CYC) begin n_fail++; $display("FAIL hold_done1: got %0d, required %0d", d1, DONE_CYC); end
      n_checks++;
      if (r2 !== RISE2_CYC) begin n_fail++; $display("FAIL hold_busy_rise2: got %0d, required %0d", r2, RISE2_CYC); end
      n_checks++;
      if (d2 !== DONE2_CYC) begin n_fail++; $display("FAIL hold_done2: got %0d, required %0d", d2, DONE2_CYC); end
      n_checks++;
      if ({pass, captured} !== {1'b1, 16'h6996}) begin
         n_fail++;
         $display("FAIL hold_result: pass=%b captured=%h, required 1 6996", pass, captured);
      end
   endtask

   initial begin
      test_reset();
      test_xor_pass();
      test_single_error();
      test_all_errors();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
